// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  typedef enum logic [1:0] {RowNone, RowOne, RowMulti} row_class_e;

  localparam int unsigned MaxRows = 8;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] n_low;
  } onehot_t;

  function automatic int unsigned calc_code_w(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  // Unused upper rows must be padded high by the caller.
  function automatic onehot_t onehot_idx(input logic [MaxRows-1:0] row_n);
    onehot_t r;
    r = '0;
    for (int i = 0; i < MaxRows; i++) begin
      if (!row_n[i]) begin
        r.idx   = 3'(i);
        r.n_low = r.n_low + 4'd1;
      end
    end
    return r;
  endfunction

  function automatic row_class_e classify(input onehot_t oh);
    if (oh.n_low == 4'd0) return RowNone;
    if (oh.n_low == 4'd1) return RowOne;
    return RowMulti;
  endfunction

endpackage

// File: rtl/keypad_scan_div.sv
// Column dwell divider: tick_o is high for one cycle every SCAN_DIV cycles.
module keypad_scan_div #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntW'(SCAN_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, press/release debounce, auto-repeat and ghost detection.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_TICKS = 0,
  localparam int unsigned CODE_W      = calc_code_w(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int unsigned ColW   = $clog2(COLS);
  localparam int unsigned CntW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RepMax = (REPEAT_TICKS > 0) ? REPEAT_TICKS : 1;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [ROWS-1:0]   row_s1_q, row_s_q;
  state_e            state_q;
  logic [COLS-1:0]   col_drive_q;
  logic [ColW-1:0]   col_idx_q;
  logic [CODE_W-1:0] cand_q, key_code_q;
  logic              key_valid_q, key_held_q, key_release_q, multi_key_q;
  logic [CntW-1:0]   cnt_q, rel_q;
  logic [RepW-1:0]   rep_q;

  logic              tick;
  logic [MaxRows-1:0] row_pad;
  onehot_t           oh;
  row_class_e        cls;
  logic [CODE_W-1:0] code;
  logic [COLS-1:0]   col_rot;
  logic [ColW-1:0]   col_idx_inc;

  keypad_scan_div #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick)
  );

  always_comb begin
    row_pad             = '1;
    row_pad[ROWS-1:0]   = row_s_q;
    oh                  = onehot_idx(row_pad);
    cls                 = classify(oh);
    code                = CODE_W'(32'(col_idx_q) * ROWS + 32'(oh.idx));
    col_rot             = {col_drive_q[COLS-2:0], col_drive_q[COLS-1]};
    col_idx_inc         = (col_idx_q == ColW'(COLS - 1)) ? '0 : col_idx_q + ColW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q      <= '1;
      row_s_q       <= '1;
      state_q       <= StScan;
      col_drive_q   <= {{(COLS-1){1'b1}}, 1'b0};
      col_idx_q     <= '0;
      cand_q        <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_key_q   <= 1'b0;
      cnt_q         <= '0;
      rel_q         <= '0;
      rep_q         <= '0;
    end else begin
      row_s1_q      <= row;
      row_s_q       <= row_s1_q;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      multi_key_q   <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (cls == RowOne) begin
              cand_q <= code;
              cnt_q  <= CntW'(1);
              if (DEBOUNCE == 1) begin
                key_code_q  <= code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= '0;
                rep_q       <= '0;
                state_q     <= StPressed;
              end else begin
                state_q <= StDebounce;
              end
            end else begin
              multi_key_q <= (cls == RowMulti);
              col_drive_q <= col_rot;
              col_idx_q   <= col_idx_inc;
            end
          end
          StDebounce: begin
            if (cls == RowOne && code == cand_q) begin
              if (32'(cnt_q) + 32'd1 >= DEBOUNCE) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                rel_q       <= '0;
                rep_q       <= '0;
                state_q     <= StPressed;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end else begin
              multi_key_q <= (cls == RowMulti);
              col_drive_q <= col_rot;
              col_idx_q   <= col_idx_inc;
              cnt_q       <= '0;
              state_q     <= StScan;
            end
          end
          StPressed: begin
            if (cls == RowNone) begin
              if (32'(rel_q) + 32'd1 >= DEBOUNCE) begin
                key_release_q <= 1'b1;
                key_held_q    <= 1'b0;
                col_drive_q   <= col_rot;
                col_idx_q     <= col_idx_inc;
                rel_q         <= '0;
                rep_q         <= '0;
                state_q       <= StScan;
              end else begin
                rel_q <= rel_q + CntW'(1);
              end
            end else begin
              rel_q       <= '0;
              multi_key_q <= (cls == RowMulti) || (code != key_code_q);
              // Repeat only advances on ticks where the key is seen down.
              if (REPEAT_TICKS > 0) begin
                if (32'(rep_q) + 32'd1 >= REPEAT_TICKS) begin
                  rep_q       <= '0;
                  key_valid_q <= 1'b1;
                end else begin
                  rep_q <= rep_q + RepW'(1);
                end
              end
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  assign col_drive   = col_drive_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;
  assign multi_key   = multi_key_q;

endmodule
